// File: rtl/buzz_pkg.sv
// Shared definitions for the buzzer event scheduler: event codes, per-event
// tone table and FSM states. Event code order doubles as priority order.
package buzz_pkg;

    typedef enum logic [1:0] {
        EV_FOUL    = 2'd0,
        EV_TIMEOUT = 2'd1,
        EV_LOCK    = 2'd2,
        EV_HOST    = 2'd3
    } event_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [15:0] DIV_FOUL    = 16'd19181;
    localparam logic [15:0] DIV_TIMEOUT = 16'd23000;
    localparam logic [15:0] DIV_LOCK    = 16'd15408;
    localparam logic [15:0] DIV_HOST    = 16'd27000;

    localparam logic [1:0] BEEPS_FOUL    = 2'd3;
    localparam logic [1:0] BEEPS_TIMEOUT = 2'd2;
    localparam logic [1:0] BEEPS_LOCK    = 2'd1;
    localparam logic [1:0] BEEPS_HOST    = 2'd1;

    function automatic logic [15:0] ev_div(input event_e e);
        case (e)
            EV_FOUL:    return DIV_FOUL;
            EV_TIMEOUT: return DIV_TIMEOUT;
            EV_LOCK:    return DIV_LOCK;
            default:    return DIV_HOST;
        endcase
    endfunction

    function automatic logic [1:0] ev_beeps(input event_e e);
        case (e)
            EV_FOUL:    return BEEPS_FOUL;
            EV_TIMEOUT: return BEEPS_TIMEOUT;
            EV_LOCK:    return BEEPS_LOCK;
            default:    return BEEPS_HOST;
        endcase
    endfunction

    // Pending vector is indexed by event code; lowest set bit wins.
    function automatic event_e pick(input logic [3:0] p);
        if (p[0])      return EV_FOUL;
        else if (p[1]) return EV_TIMEOUT;
        else if (p[2]) return EV_LOCK;
        else           return EV_HOST;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// Loadable down-counter timing one beep or gap; done while the count is zero.
module ms_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (start)
            cnt <= load;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/buzz_sched.sv
// Buzzer event scheduler: edge-detects event requests, queues them by priority
// and plays each event's beep pattern as a tone divisor plus enable.
module buzz_sched
    import buzz_pkg::*;
#(
    parameter int CLK_PER_MS = 50000,
    parameter int BEEP_MS    = 200,
    parameter int GAP_MS     = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_foul,
    input  logic        req_lock,
    input  logic        req_host,
    input  logic        req_timeout,
    input  logic        flush,
    input  logic        mute,
    output logic [15:0] tone_div,
    output logic        tone_en,
    output logic        busy,
    output logic [1:0]  cur_event
);

    localparam int PLAY_CYC = BEEP_MS * CLK_PER_MS;
    localparam int GAP_CYC  = GAP_MS * CLK_PER_MS;
    localparam int MAX_CYC  = (BEEP_MS > GAP_MS ? BEEP_MS : GAP_MS) * CLK_PER_MS;
    localparam int TW       = $clog2(MAX_CYC + 1);

    logic [3:0]    req_now, req_d, edges, pending, pending_nxt, gmask;
    state_e        state, state_nxt;
    event_e        cur, cur_nxt, grant_ev;
    logic [1:0]    beeps, beeps_nxt;
    logic [15:0]   div_nxt;
    logic          tone_en_nxt, grant;
    logic          tmr_start, tmr_done;
    logic [TW-1:0] tmr_load;

    assign req_now = {req_host, req_lock, req_timeout, req_foul};
    assign edges   = req_now & ~req_d;

    ms_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (tmr_start),
        .load  (tmr_load),
        .done  (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            req_d    <= '0;
            pending  <= '0;
            cur      <= EV_FOUL;
            beeps    <= '0;
            tone_div <= '0;
            tone_en  <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_d    <= req_now;
            pending  <= pending_nxt;
            cur      <= cur_nxt;
            beeps    <= beeps_nxt;
            tone_div <= div_nxt;
            tone_en  <= tone_en_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        beeps_nxt = beeps;
        div_nxt   = tone_div;
        grant     = 1'b0;
        tmr_start = 1'b0;
        tmr_load  = TW'(PLAY_CYC - 1);
        grant_ev  = pick(pending);
        gmask     = 4'b0001 << grant_ev;

        case (state)
            ST_IDLE: grant = |pending;
            ST_PLAY: begin
                // A pending foul aborts any other event outright.
                if (pending[EV_FOUL] && cur != EV_FOUL)
                    grant = 1'b1;
                else if (tmr_done) begin
                    state_nxt = ST_GAP;
                    beeps_nxt = beeps - 2'd1;
                    tmr_start = 1'b1;
                    tmr_load  = TW'(GAP_CYC - 1);
                end
            end
            ST_GAP: begin
                if (pending[EV_FOUL] && cur != EV_FOUL)
                    grant = 1'b1;
                else if (tmr_done) begin
                    if (beeps != 2'd0) begin
                        state_nxt = ST_PLAY;
                        tmr_start = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        pending_nxt = pending;
        if (grant) begin
            state_nxt   = ST_PLAY;
            cur_nxt     = grant_ev;
            div_nxt     = ev_div(grant_ev);
            beeps_nxt   = ev_beeps(grant_ev);
            tmr_start   = 1'b1;
            tmr_load    = TW'(PLAY_CYC - 1);
            pending_nxt = pending_nxt & ~gmask;
        end
        // New edges re-arm even the event being granted this cycle.
        pending_nxt = pending_nxt | edges;

        if (flush) begin
            state_nxt   = ST_IDLE;
            pending_nxt = '0;
        end

        tone_en_nxt = (state_nxt == ST_PLAY) && !mute;
    end

    assign busy      = (state != ST_IDLE);
    assign cur_event = cur;

endmodule

// File: tb/tb_buzz_sched.sv
// Directed bench for buzz_sched with short timings (PLAY 8 cycles, GAP 4).
module tb_buzz_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_foul, req_lock, req_host, req_timeout, flush, mute;
    logic [15:0] tone_div;
    logic        tone_en, busy;
    logic [1:0]  cur_event;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    buzz_sched #(.CLK_PER_MS(4), .BEEP_MS(2), .GAP_MS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_foul    (req_foul),
        .req_lock    (req_lock),
        .req_host    (req_host),
        .req_timeout (req_timeout),
        .flush       (flush),
        .mute        (mute),
        .tone_div    (tone_div),
        .tone_en     (tone_en),
        .busy        (busy),
        .cur_event   (cur_event)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] dv);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"}, tone_en, 0);
        chk({tag, "_div"}, tone_div, dv);
    endtask

    // Walks nb beeps of 8 tone cycles + 4 silent cycles, ending one cycle after.
    task automatic play(input string tag, input logic [1:0] ev, input logic [15:0] dv,
                        input int nb, input logic muted);
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 12; i++) begin
                chk({tag, "_en"}, tone_en, (i < 8) && !muted);
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_div"}, tone_div, dv);
                chk({tag, "_ev"}, cur_event, ev);
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        {req_foul, req_lock, req_host, req_timeout, flush, mute} = '0;
        #1;
        chk("rst_div", tone_div, 0);
        chk("rst_en", tone_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ev", cur_event, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_idle("post_rst", 16'd0);

        // single-beep lock
        req_lock = 1'b1;
        tick();
        chk("lock_lat_busy", busy, 0);
        tick();
        play("lock", 2'd2, 16'd15408, 1, 1'b0);
        chk_idle("lock_done", 16'd15408);
        req_lock = 1'b0;
        tick();

        // three-beep foul
        req_foul = 1'b1;
        tick(); tick();
        play("foul", 2'd0, 16'd19181, 3, 1'b0);
        chk_idle("foul_done", 16'd19181);
        req_foul = 1'b0;
        tick();

        // foul preempts host at PLAY cycle 3
        req_host = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("host_pre_en", tone_en, 1);
            chk("host_pre_div", tone_div, 27000);
            tick();
        end
        req_foul = 1'b1;
        tick();
        chk("host_still_ev", cur_event, 3);
        chk("host_still_div", tone_div, 27000);
        tick();
        play("preempt", 2'd0, 16'd19181, 3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_idle("no_resume", 16'd19181);
            tick();
        end
        req_foul = 1'b0;
        req_host = 1'b0;
        tick();

        // simultaneous lock + host: lock first, then host
        req_lock = 1'b1;
        req_host = 1'b1;
        tick(); tick();
        play("sim_lock", 2'd2, 16'd15408, 1, 1'b0);
        chk_idle("sim_gap", 16'd15408);
        tick();
        play("sim_host", 2'd3, 16'd27000, 1, 1'b0);
        chk_idle("sim_done", 16'd27000);
        req_lock = 1'b0;
        req_host = 1'b0;
        tick();

        // muted timeout: silent but busy for 24 cycles
        mute = 1'b1;
        req_timeout = 1'b1;
        tick(); tick();
        play("mute_to", 2'd1, 16'd23000, 2, 1'b1);
        chk_idle("mute_done", 16'd23000);
        mute = 1'b0;
        req_timeout = 1'b0;
        tick();

        // async reset mid-PLAY; level held across release is a new request
        req_lock = 1'b1;
        tick(); tick(); tick(); tick();
        chk("mid_play_en", tone_en, 1);
        rst = 1'b0;
        #1;
        chk("arst_div", tone_div, 0);
        chk("arst_en", tone_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ev", cur_event, 0);
        tick();
        rst = 1'b1;
        tick(); tick();
        chk("relock_busy", busy, 1);
        chk("relock_en", tone_en, 1);
        chk("relock_div", tone_div, 15408);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk_idle("flush1", 16'd15408);
        req_lock = 1'b0;
        tick();

        // flush clears pending lock and wins over a same-cycle host edge
        req_timeout = 1'b1;
        tick(); tick();
        chk("to_play_div", tone_div, 23000);
        req_lock = 1'b1;
        tick();
        req_host = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk_idle("flush2", 16'd23000);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
